hps_reset_sequencer: RTL

HPS_RESET_SEQUENCER -- requirements
Module: hps_reset_sequencer

---
 rtl/hps_reset_sequencer.sv | 89 ++++++++
 1 files changed

// File: rtl/hps_reset_sequencer.sv
// hps_reset_sequencer: holds FPGA reset domains after any reset source, then releases them one by one in index order.
module hps_reset_sequencer #(
  parameter int NUM_STAGES  = 3,
  parameter int HOLD_CYCLES = 16,
  parameter int STAGE_DELAY = 8,
  parameter int CNT_WIDTH   = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  h2f_reset_n,
  input  logic                  pll_locked,
  input  logic                  sw_reset_req,
  output logic [NUM_STAGES-1:0] fpga_reset_n,
  output logic                  seq_busy,
  output logic                  seq_done,
  output logic [7:0]            reset_count
);
  localparam int IW = $clog2(NUM_STAGES + 1);
  localparam logic [CNT_WIDTH-1:0]  HOLD_LAST = CNT_WIDTH'(HOLD_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0]  DLY_LAST  = CNT_WIDTH'(STAGE_DELAY - 1);
  localparam logic [CNT_WIDTH-1:0]  CNT_ONE   = CNT_WIDTH'(1);
  localparam logic [IW-1:0]         LAST_IDX  = IW'(NUM_STAGES - 1);
  localparam logic [IW-1:0]         IDX_ONE   = IW'(1);
  localparam logic [NUM_STAGES-1:0] STAGE0    = NUM_STAGES'(1);
  typedef enum logic [1:0] {ASSERT, RELEASE, RUN} state_e;
  state_e                state_q;
  logic [1:0]            h_sync_q, p_sync_q, s_sync_q;
  logic                  s_prev_q;
  logic [CNT_WIDTH-1:0]  cnt_q;
  logic [IW-1:0]         idx_q;
  logic [NUM_STAGES-1:0] rstn_q;
  logic [7:0]            count_q;
  logic                  sw_pulse, src_active;
  always_ff @(posedge clk) begin
    if (rst) begin
      h_sync_q <= '0;
      p_sync_q <= '0;
      s_sync_q <= '0;
      s_prev_q <= 1'b0;
    end else begin
      h_sync_q <= {h_sync_q[0], h2f_reset_n};
      p_sync_q <= {p_sync_q[0], pll_locked};
      s_sync_q <= {s_sync_q[0], sw_reset_req};
      s_prev_q <= s_sync_q[1];
    end
  end
  assign sw_pulse   = s_sync_q[1] & ~s_prev_q;
  assign src_active = ~h_sync_q[1] | ~p_sync_q[1] | sw_pulse;
  // A source seen outside ASSERT always wins, even over a release due on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ASSERT;
      cnt_q   <= '0;
      idx_q   <= '0;
      rstn_q  <= '0;
      count_q <= '0;
    end else if (state_q == ASSERT) begin
      rstn_q <= '0;
      if (src_active) begin
        cnt_q <= '0;
      end else if (cnt_q == HOLD_LAST) begin
        state_q <= (NUM_STAGES == 1) ? RUN : RELEASE;
        rstn_q  <= STAGE0;
        cnt_q   <= '0;
        idx_q   <= IDX_ONE;
      end else begin
        cnt_q <= cnt_q + CNT_ONE;
      end
    end else if (src_active) begin
      state_q <= ASSERT;
      rstn_q  <= '0;
      cnt_q   <= '0;
      count_q <= (count_q == 8'hFF) ? count_q : count_q + 8'd1;
    end else if (state_q == RELEASE) begin
      if (cnt_q == DLY_LAST) begin
        rstn_q  <= rstn_q | (STAGE0 << idx_q);
        cnt_q   <= '0;
        idx_q   <= idx_q + IDX_ONE;
        state_q <= (idx_q == LAST_IDX) ? RUN : RELEASE;
      end else begin
        cnt_q <= cnt_q + CNT_ONE;
      end
    end
  end
  assign fpga_reset_n = rstn_q;
  assign seq_busy     = state_q != RUN;
  assign seq_done     = state_q == RUN;
  assign reset_count  = count_q;
endmodule
